// File: rtl/argmax_stream_ctrl.sv
// argmax_stream_ctrl: streams NUM_CLASSES signed scores per frame and reports the
//   index and value of the largest one. Ties keep the lowest index.
// Latency: out_valid rises the cycle after the final score is accepted.
// Backpressure: in_ready depends on state only; the result is held stable until out_ready.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, abort         begin a frame / cancel the current frame (abort wins)
//   in_valid/in_ready    score handshake, in_data = signed score in class order
//   out_valid/out_ready  result handshake, out_index/out_value = argmax result
//   busy                 high while a frame is being accumulated or presented
module argmax_stream_ctrl #(
  parameter int BIT_WIDTH   = 8,
  parameter int INDEX_WIDTH = 4,
  parameter int NUM_CLASSES = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [BIT_WIDTH-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic        [INDEX_WIDTH-1:0] out_index,
  output logic signed [BIT_WIDTH-1:0]   out_value,
  output logic                          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_CLASSES - 1);

  state_t                        state;
  logic        [INDEX_WIDTH-1:0] count;
  logic signed [BIT_WIDTH-1:0]   best_val;
  logic        [INDEX_WIDTH-1:0] best_idx;

  logic                          accept;
  logic                          take_new;
  logic signed [BIT_WIDTH-1:0]   cand_val;
  logic        [INDEX_WIDTH-1:0] cand_idx;

  // Handshake and status flags are pure decodes of the state register, so they
  // are glitch-free and never depend on in_valid.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign accept = in_valid & in_ready;

  // The first score of a frame always seeds the running best; afterwards only a
  // strictly larger score replaces it, which keeps the earliest index on ties.
  assign take_new = (count == '0) || (in_data > best_val);
  assign cand_val = take_new ? in_data : best_val;
  assign cand_idx = take_new ? count   : best_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      best_val  <= '0;
      best_idx  <= '0;
      out_index <= '0;
      out_value <= '0;
    end else if (abort) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ACCUM;
            count <= '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            best_val <= cand_val;
            best_idx <= cand_idx;
            if (count == LAST_IDX) begin
              // The final comparison result goes straight to the output
              // registers, saving a cycle of latency.
              state     <= DONE;
              count     <= '0;
              out_index <= cand_idx;
              out_value <= cand_val;
            end else begin
              count <= count + INDEX_WIDTH'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= start ? ACCUM : IDLE;
            count <= '0;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule
